// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and link defaults common to rx and tx.
package uart_pkg;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_e;

  localparam int UART_CLKS_PER_BIT = 8;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1-style serial receiver with a one-entry valid/ready output buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  logic                 rxs;
  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt, bit_inc;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 deliver, ferr;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Shift register holds only payload; it is fully overwritten before every delivery.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    bit_inc     = bit_cnt + 1'b1;
    shreg_nxt   = shreg;
    deliver     = 1'b0;
    ferr        = 1'b0;
    case (state)
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        // LSB arrives first, so right-shifting leaves bit 0 in position 0 after the last sample.
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_inc;
          if (bit_inc == BIT_W'(DATA_BITS)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          if (rxs) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_nxt = WAIT_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output buffer: a consume on the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= deliver && m_valid && !m_ready;
      if (deliver && (!m_valid || m_ready)) begin
        m_data  <= shreg;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
